fwd_hazard_unit: RTL and testbench

- Parametrised successor to the fixed two-deep forwarding detector in the decode stage of the SIMPLE 16-bit pipeline.
- Tracks destination registers of up to DEPTH in-flight instructions in a registered shift pipe.
- Produces per-operand forwarding selects and a load-use stall for the instruction in decode.
- Sits between DecodeUnit (which supplies already-decoded fields) and the operand muxes and PC/IR enables.

---
 rtl/fwd_hazard_unit.sv | 143 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand forwarding and load-use hazard detection for the decode stage of the
// SIMPLE 16-bit pipeline. A registered shift pipe remembers the destination
// register of the last DEPTH issued instructions. Entry 1 is the instruction
// one stage ahead of decode, and entry DEPTH is the oldest. The instruction
// currently in decode is compared against that pipe in the same cycle.
//
// Parameters
//   REG_AW   register address width
//   DEPTH    number of in-flight entries tracked (1..7)
//   LOAD_LAT a load in entry k has no data yet while k <= LOAD_LAT
//            (0 <= LOAD_LAT < DEPTH)
//   SW       selector width, derived as clog2(DEPTH+1)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   issue_valid         decode holds a real instruction
//   src_a / src_a_en    operand A register and its read enable
//   src_b / src_b_en    operand B register and its read enable
//   dst / dst_we        destination register and its write enable
//   is_load             instruction takes its result from memory
//   flush               taken branch: drop every tracked entry
//   fwd_a / fwd_b       0 = register file, k = forward from entry k
//   stall               load-use hazard: hold PC/IR and insert a bubble
//   stall_cnt, fwd_cnt  saturating statistics, only with FWD_STATS_EN
//
// Optional feature macro: FWD_STATS_EN (adds stall_cnt / fwd_cnt).
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW   = 3,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] src_a,
  input  logic              src_a_en,
  input  logic [REG_AW-1:0] src_b,
  input  logic              src_b_en,
  input  logic [REG_AW-1:0] dst,
  input  logic              dst_we,
  input  logic              is_load,
  input  logic              flush,
  output logic [SW-1:0]     fwd_a,
  output logic [SW-1:0]     fwd_b,
  output logic              stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fwd_cnt
`endif
);

  // Tracked entries, index 1 = youngest.
  logic [DEPTH:1]    ent_v;
  logic [DEPTH:1]    ent_ld;
  logic [REG_AW-1:0] ent_a [1:DEPTH];

  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic          haz_a;
  logic          haz_b;

  // Scan from oldest to youngest so the youngest matching writer overwrites
  // any older one. The hazard flag follows the chosen entry only, so an older
  // pending load shadowed by a younger ALU writer does not stall.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_a_en && ent_v[k] && (ent_a[k] == src_a)) begin
        sel_a = SW'(k);
        haz_a = ent_ld[k] && (k <= LOAD_LAT);
      end
      if (src_b_en && ent_v[k] && (ent_a[k] == src_b)) begin
        sel_b = SW'(k);
        haz_b = ent_ld[k] && (k <= LOAD_LAT);
      end
    end
  end

  // An empty decode slot neither forwards nor stalls.
  assign fwd_a = issue_valid ? sel_a : '0;
  assign fwd_b = issue_valid ? sel_b : '0;
  assign stall = issue_valid & (haz_a | haz_b);

  // Shift pipe. A stalled instruction does not enter the pipe; it re-presents
  // from decode next cycle, and entry 1 receives a bubble meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v  <= '0;
      ent_ld <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        ent_a[k] <= '0;
      end
    end else if (flush) begin
      ent_v <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_v[k]  <= ent_v[k-1];
        ent_ld[k] <= ent_ld[k-1];
        ent_a[k]  <= ent_a[k-1];
      end
      ent_v[1]  <= issue_valid & dst_we & ~stall;
      ent_ld[1] <= is_load;
      ent_a[1]  <= dst;
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] fwd_cnt_q;
  logic        fwd_issue;

  // An issue counts as forwarded only when it actually leaves decode.
  assign fwd_issue = issue_valid & ~stall & ((fwd_a != '0) | (fwd_b != '0));

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (fwd_issue && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed scenarios with literal expectations, followed by random traffic.
// A queue-based model of the in-flight writers supplies the expected outputs,
// and a negedge process compares them against the DUT on every cycle.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int REG_AW   = 3;
  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;
  localparam int SW       = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic              issue_valid;
  logic [REG_AW-1:0] src_a;
  logic              src_a_en;
  logic [REG_AW-1:0] src_b;
  logic              src_b_en;
  logic [REG_AW-1:0] dst;
  logic              dst_we;
  logic              is_load;
  logic              flush;
  logic [SW-1:0]     fwd_a;
  logic [SW-1:0]     fwd_b;
  logic              stall;
`ifdef FWD_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       fwd_cnt;
`endif

  fwd_hazard_unit #(
    .REG_AW  (REG_AW),
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .src_a      (src_a),
    .src_a_en   (src_a_en),
    .src_b      (src_b),
    .src_b_en   (src_b_en),
    .dst        (dst),
    .dst_we     (dst_we),
    .is_load    (is_load),
    .flush      (flush),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall      (stall)
`ifdef FWD_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .fwd_cnt    (fwd_cnt)
`endif
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Writers in flight, youngest first; a missing tail entry means "nothing".
  typedef struct {
    bit              v;
    bit [REG_AW-1:0] a;
    bit              ld;
  } ent_t;

  ent_t pipe[$];
  logic [15:0] m_stall_cnt = '0;
  logic [15:0] m_fwd_cnt   = '0;

  // Operand selects: position of the first (youngest) in-flight writer of the
  // register; stall when that writer is a load still waiting for memory.
  function automatic void model_eval(output int fa, output int fb, output int st);
    fa = 0;
    fb = 0;
    st = 0;
    for (int i = 0; i < pipe.size(); i++) begin
      if (fa == 0 && src_a_en && pipe[i].v && pipe[i].a == src_a) begin
        fa = i + 1;
        if (pipe[i].ld && (i + 1) <= LOAD_LAT) st = 1;
      end
      if (fb == 0 && src_b_en && pipe[i].v && pipe[i].a == src_b) begin
        fb = i + 1;
        if (pipe[i].ld && (i + 1) <= LOAD_LAT) st = 1;
      end
    end
    if (!issue_valid) begin
      fa = 0;
      fb = 0;
      st = 0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int fa, fb, st;
    ent_t e;
    if (!rst_n) begin
      pipe.delete();
      m_stall_cnt = '0;
      m_fwd_cnt   = '0;
    end else begin
      model_eval(fa, fb, st);
      if (st != 0 && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
      if (issue_valid && st == 0 && (fa != 0 || fb != 0) && m_fwd_cnt != 16'hFFFF)
        m_fwd_cnt = m_fwd_cnt + 16'd1;
      if (flush) begin
        pipe.delete();
      end else begin
        e.v  = issue_valid && dst_we && (st == 0);
        e.a  = dst;
        e.ld = is_load;
        pipe.push_front(e);
        while (pipe.size() > DEPTH) void'(pipe.pop_back());
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    int fa, fb, st;
    model_eval(fa, fb, st);
    chk("model_fwd_a", 32'(fwd_a), 32'(fa));
    chk("model_fwd_b", 32'(fwd_b), 32'(fb));
    chk("model_stall", 32'(stall), 32'(st));
`ifdef FWD_STATS_EN
    chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    chk("model_fwd_cnt",   32'(fwd_cnt),   32'(m_fwd_cnt));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v,
                       input logic [REG_AW-1:0] sa, input logic sae,
                       input logic [REG_AW-1:0] sb, input logic sbe,
                       input logic [REG_AW-1:0] d,  input logic dwe,
                       input logic ld, input logic fl);
    issue_valid = v;
    src_a = sa; src_a_en = sae;
    src_b = sb; src_b_en = sbe;
    dst   = d;  dst_we   = dwe;
    is_load = ld;
    flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Literal expectations, sampled mid-cycle.
  task automatic expect3(input string nm, input int ea, input int eb, input int es);
    #2;
    chk({nm, "_fwd_a"}, 32'(fwd_a), 32'(ea));
    chk({nm, "_fwd_b"}, 32'(fwd_b), 32'(eb));
    chk({nm, "_stall"}, 32'(stall), 32'(es));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    expect3("reset", 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // ADD r5 issued; next cycle AND reads r7/r5.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    expect3("add_r5", 0, 0, 0);
    step();
    drive(1, 7, 1, 5, 1, 0, 0, 0, 0);
    expect3("and_fwd1", 0, 1, 0);
    step();
    // LD r1 <- [r7], also reading r5, which now sits in entry 2.
    drive(1, 7, 1, 5, 1, 1, 1, 1, 0);
    expect3("ld_fwd2", 0, 2, 0);
    step();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    expect3("r5_retired", 0, 0, 0);
    step();
    idle(); step(); step();

    // Load-use: one stall cycle, then forward from entry 2.
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
    expect3("ld_r3", 0, 0, 0);
    step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    expect3("loaduse_stall", 1, 0, 1);
    step();
    expect3("loaduse_resolve", 2, 0, 0);
    step();
    idle(); step(); step();

    // Two writers of r4: the youngest wins on both operands.
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step();
    step();
    drive(1, 4, 1, 4, 1, 0, 0, 0, 0);
    expect3("r4_youngest", 1, 1, 0);
    step();
    idle(); step(); step();

    // Flush on the stalling edge clears the hazard.
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    step();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 1);
    expect3("flush_stall", 1, 0, 1);
    step();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
    expect3("after_flush", 0, 0, 0);
    step();
    idle(); step();

    // Asynchronous reset during a stall.
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
    step();
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
    expect3("prereset_stall", 1, 0, 1);
    rst_n = 1'b0;
    #1;
    expect3("async_reset", 0, 0, 0);
    idle();
    step();
    rst_n = 1'b1;
    step();

`ifdef FWD_STATS_EN
    // Three load-use sequences (each: one stall, one forwarded issue) and one
    // plain forwarded issue.
    chk("stats_reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("stats_reset_fwd_cnt",   32'(fwd_cnt),   32'd0);
    for (int n = 0; n < 3; n++) begin
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
      step();
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
      step();
      step();
      idle();
      step();
      step();
    end
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    step();
    idle();
    step();
    #2;
    chk("stats_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("stats_fwd_cnt",   32'(fwd_cnt),   32'd4);
    step();

    // Saturation: preload near the top, then stall every other cycle.
    dut.stall_cnt_q = 16'hFFFD;
    m_stall_cnt     = 16'hFFFD;
    drive(1, 2, 1, 0, 0, 2, 1, 1, 0);
    for (int n = 0; n < 12; n++) step();
    idle();
    step();
    #2;
    chk("stats_saturate", 32'(stall_cnt), 32'hFFFF);
    step();
`endif

    // Random traffic; small register range for frequent hits.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 7) != 0),
            REG_AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            REG_AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            REG_AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0));
      step();
    end
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
